// File: rtl/instr_issue_unit.sv
// Instruction issue unit: plays a loaded program buffer into the R-type datapath,
// inserting NOP bubbles when a word reads a register written by a recent issue.
module instr_issue_unit #(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int HAZ_DIST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              start,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              zf_in,
    output logic [31:0]       instruccion,
    output logic              valid,
    output logic              busy,
    output logic              done,
    output logic [7:0]        bubbles,
    output logic              zf_last
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   len_clamp;
    logic [4:0]        hist_rd   [HAZ_DIST];
    logic              hist_live [HAZ_DIST];

    logic [31:0] cur_word;
    logic [4:0]  cur_rs, cur_rt, cur_rd;
    logic        hazard;
    logic        last_word;
    logic        start_any, start_play, do_issue, do_bubble, do_finish;

    assign cur_word  = mem[pc_q];
    assign cur_rs    = cur_word[25:21];
    assign cur_rt    = cur_word[20:16];
    assign cur_rd    = cur_word[15:11];
    assign len_clamp = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign last_word = ({1'b0, pc_q} == (len_q - LEN_ONE));

    // Register 0 is hard-wired, so a writer of rd=0 never blocks a reader.
    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < HAZ_DIST; i++) begin
            if (hist_live[i] && (hist_rd[i] != '0) &&
                ((hist_rd[i] == cur_rs) || (hist_rd[i] == cur_rt))) begin
                hazard = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        start_any  = 1'b0;
        start_play = 1'b0;
        do_issue   = 1'b0;
        do_bubble  = 1'b0;
        do_finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_any = 1'b1;
                    if (len_clamp != '0) begin
                        start_play = 1'b1;
                        state_d    = ISSUE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ISSUE: begin
                if (hazard) begin
                    do_bubble = 1'b1;
                end else begin
                    do_issue = 1'b1;
                    if (last_word) state_d = DONE;
                end
            end
            DONE: begin
                do_finish = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Program buffer survives reset; writes are only honoured while idle.
    always_ff @(posedge clk) begin
        if (wr_en && (state_q == IDLE)) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            len_q       <= '0;
            instruccion <= '0;
            valid       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            bubbles     <= '0;
            zf_last     <= 1'b0;
            for (int unsigned i = 0; i < HAZ_DIST; i++) begin
                hist_rd[i]   <= '0;
                hist_live[i] <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            done    <= do_finish;
            if (valid) zf_last <= zf_in;

            if (state_q == IDLE) begin
                instruccion <= '0;
                valid       <= 1'b0;
            end

            if (start_any) bubbles <= '0;

            if (start_play) begin
                pc_q  <= '0;
                len_q <= len_clamp;
                busy  <= 1'b1;
                for (int unsigned i = 0; i < HAZ_DIST; i++) begin
                    hist_rd[i]   <= '0;
                    hist_live[i] <= 1'b0;
                end
            end

            if (do_issue || do_bubble) begin
                for (int unsigned i = 1; i < HAZ_DIST; i++) begin
                    hist_rd[i]   <= hist_rd[i-1];
                    hist_live[i] <= hist_live[i-1];
                end
            end

            if (do_issue) begin
                instruccion  <= cur_word;
                valid        <= 1'b1;
                hist_rd[0]   <= cur_rd;
                hist_live[0] <= 1'b1;
                if (!last_word) pc_q <= pc_q + ADDR_ONE;
            end

            if (do_bubble) begin
                instruccion  <= '0;
                valid        <= 1'b0;
                hist_rd[0]   <= '0;
                hist_live[0] <= 1'b0;
                if (bubbles != 8'hFF) bubbles <= bubbles + 8'd1;
            end

            if (do_finish) begin
                instruccion <= '0;
                valid       <= 1'b0;
                busy        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_issue_unit.sv
// Bench for instr_issue_unit: two instances (HAZ_DIST=1 and 2) driven in parallel
// and compared cycle-by-cycle against a register-scoreboard model of the issue rules.
module tb_instr_issue_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        start = 1'b0;
    logic [4:0]  prog_len = '0;
    logic        zf_in = 1'b0;

    logic [31:0] instr_o [2];
    logic        valid_o [2];
    logic        busy_o  [2];
    logic        done_o  [2];
    logic [7:0]  bub_o   [2];
    logic        zfl_o   [2];

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] prog [16];
    logic [32:0] mq [$];
    logic [32:0] exp0 [$];
    logic [32:0] exp1 [$];
    int          lens    [2];
    int          bub_exp [2];
    logic        zfm     [2];
    logic        prev_v  [2];

    always #5 clk = ~clk;

    instr_issue_unit #(.DEPTH(16), .ADDR_W(4), .HAZ_DIST(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .prog_len(prog_len), .zf_in(zf_in),
        .instruccion(instr_o[0]), .valid(valid_o[0]), .busy(busy_o[0]),
        .done(done_o[0]), .bubbles(bub_o[0]), .zf_last(zfl_o[0])
    );

    instr_issue_unit #(.DEPTH(16), .ADDR_W(4), .HAZ_DIST(2)) dut2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .prog_len(prog_len), .zf_in(zf_in),
        .instruccion(instr_o[1]), .valid(valid_o[1]), .busy(busy_o[1]),
        .done(done_o[1]), .bubbles(bub_o[1]), .zf_last(zfl_o[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue slot t may take a word only if none of its nonzero sources was
    // written at slot t-1 .. t-haz; otherwise that slot is a NOP.
    function automatic int build_model(input int haz, input int len);
        int last_wr [32];
        int t, pc, bub;
        logic [31:0] w;
        logic [4:0] rs, rt;
        bit stall;
        mq.delete();
        for (int r = 0; r < 32; r++) last_wr[r] = -100;
        t = 0; pc = 0; bub = 0;
        while (pc < len) begin
            w  = prog[pc];
            rs = w[25:21];
            rt = w[20:16];
            stall = (rs != 0 && last_wr[rs] >= t - haz) || (rt != 0 && last_wr[rt] >= t - haz);
            if (stall) begin
                mq.push_back({1'b0, 32'h0});
                if (bub < 255) bub++;
            end else begin
                mq.push_back({1'b1, w});
                last_wr[w[15:11]] = t;
                pc++;
            end
            t++;
        end
        return bub;
    endfunction

    task automatic load_words(input int base, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input int n);
        logic [31:0] ws [3];
        ws[0] = w0; ws[1] = w1; ws[2] = w2;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 4'(base + i); wr_data = ws[i];
            prog[base + i] = ws[i];
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic sample(input int k);
        logic [32:0] e;
        for (int d = 0; d < 2; d++) begin
            if (prev_v[d]) zfm[d] = zf_in;
            if (k < lens[d]) begin
                e = (d == 0) ? exp0[k] : exp1[k];
                check($sformatf("d%0d_instr_k%0d", d, k), instr_o[d], e[31:0]);
                check($sformatf("d%0d_valid_k%0d", d, k), 32'(valid_o[d]), 32'(e[32]));
                check($sformatf("d%0d_busy_k%0d", d, k), 32'(busy_o[d]), 32'd1);
                check($sformatf("d%0d_done_k%0d", d, k), 32'(done_o[d]), 32'd0);
                check($sformatf("d%0d_zf_k%0d", d, k), 32'(zfl_o[d]), 32'(zfm[d]));
                prev_v[d] = e[32];
            end else if (k <= lens[d] + 1) begin
                check($sformatf("d%0d_end_instr_k%0d", d, k), instr_o[d], 32'h0);
                check($sformatf("d%0d_end_valid_k%0d", d, k), 32'(valid_o[d]), 32'd0);
                check($sformatf("d%0d_end_busy_k%0d", d, k), 32'(busy_o[d]), 32'd0);
                check($sformatf("d%0d_done_k%0d", d, k), 32'(done_o[d]), 32'(k == lens[d]));
                check($sformatf("d%0d_bubbles_k%0d", d, k), 32'(bub_o[d]), 32'(bub_exp[d]));
                check($sformatf("d%0d_zf_k%0d", d, k), 32'(zfl_o[d]), 32'(zfm[d]));
                prev_v[d] = 1'b0;
            end else begin
                prev_v[d] = 1'b0;
            end
        end
        zf_in = 1'($urandom);
    endtask

    task automatic run(input logic [4:0] plen, input bit guard);
        int len, maxl;
        len = (plen > 16) ? 16 : int'(plen);
        bub_exp[0] = build_model(1, len); exp0 = mq;
        bub_exp[1] = build_model(2, len); exp1 = mq;
        lens[0] = exp0.size();
        lens[1] = exp1.size();
        maxl = (lens[0] > lens[1]) ? lens[0] : lens[1];
        @(negedge clk);
        start = 1'b1; prog_len = plen;
        @(negedge clk);
        start = 1'b0;
        if (guard && len > 0) begin
            wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hDEADBEEF;
        end
        for (int k = 0; k <= maxl + 1; k++) begin
            @(negedge clk);
            wr_en = 1'b0;
            sample(k);
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_d%0d_instr", tag, d), instr_o[d], 32'h0);
            check($sformatf("%s_d%0d_valid", tag, d), 32'(valid_o[d]), 32'd0);
            check($sformatf("%s_d%0d_busy", tag, d), 32'(busy_o[d]), 32'd0);
            check($sformatf("%s_d%0d_done", tag, d), 32'(done_o[d]), 32'd0);
            check($sformatf("%s_d%0d_bub", tag, d), 32'(bub_o[d]), 32'd0);
            check($sformatf("%s_d%0d_zf", tag, d), 32'(zfl_o[d]), 32'd0);
            zfm[d] = 1'b0;
            prev_v[d] = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) prog[i] = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        // Initialise the whole buffer so the model and DUT agree on every entry.
        for (int i = 0; i < 16; i++) load_words(i, 32'h0, 32'h0, 32'h0, 1);

        load_words(0, 32'h01E9A022, 32'h0289A022, 32'h0, 2);
        run(5'd2, 1'b0);
        check("tp_pair_bub_h1", 32'(bub_o[0]), 32'd1);

        load_words(0, 32'h00AF7820, 32'h02959020, 32'h0, 2);
        run(5'd2, 1'b0);
        check("tp_indep_bub_h1", 32'(bub_o[0]), 32'd0);

        load_words(0, 32'h01290020, 32'h00094020, 32'h0, 2);
        run(5'd2, 1'b0);
        check("tp_r0_bub_h1", 32'(bub_o[0]), 32'd0);
        check("tp_r0_bub_h2", 32'(bub_o[1]), 32'd0);

        load_words(0, 32'h01E9A022, 32'h0289A022, 32'h028FA82A, 3);
        run(5'd3, 1'b0);
        check("tp_chain_bub_h2", 32'(bub_o[1]), 32'd4);

        // Write attempted while busy must not reach the buffer; replay checks it.
        run(5'd3, 1'b1);
        run(5'd3, 1'b0);

        run(5'd0, 1'b0);

        // Asynchronous reset in the middle of a three-word playback.
        @(negedge clk);
        start = 1'b1; prog_len = 5'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_state("midrst");
        @(negedge clk);
        rst = 1'b0;
        run(5'd3, 1'b0);

        // Oversized length clamps to the full buffer.
        for (int i = 0; i < 16; i++)
            load_words(i, {6'b0, 5'(i % 4), 5'((i + 1) % 4), 5'((i + 2) % 4), 11'h020}, 32'h0, 32'h0, 1);
        run(5'd31, 1'b0);

        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 7) == 0)
                    load_words(i, 32'h0, 32'h0, 32'h0, 1);
                else
                    load_words(i, {6'b0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                                   5'($urandom_range(0, 3)), 11'h020}, 32'h0, 32'h0, 1);
            end
            run(5'($urandom_range(0, 20)), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
